// File: rtl/fetch_stage.sv
// fetch_stage: two-phase fetch/execute PC and instruction register sequencer
// Ports: clk, reset (async, active-high), enable (advance), load_pc/load_addr (jump, execute only),
//        rom_data (byte at pc_addr) -> pc_addr, instr/oprnd (IR[7:4]/IR[3:0]), phase (0 fetch, 1 execute),
//        ir_valid (IR loaded since reset), halted (sticky wrap halt).
// Option: define FETCH_WRAP_HALT_EN to halt when the PC increments past all-ones; otherwise it wraps and halted is 0.
module fetch_stage #(
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        rom_data,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [3:0]        instr,
  output logic [3:0]        oprnd,
  output logic              phase,
  output logic              ir_valid,
  output logic              halted
);
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;
  logic              r_phase;
  logic              r_valid;
  logic              w_run;
`ifdef FETCH_WRAP_HALT_EN
  logic r_halted;
  assign w_run  = enable & ~r_halted;
  assign halted = r_halted;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_halted <= 1'b0;
    else if (w_run && r_phase) r_halted <= ~load_pc & (&r_pc);
`else
  assign w_run  = enable;
  assign halted = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pc    <= RESET_VECTOR;
      r_ir    <= 8'h00;
      r_phase <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_run) begin
      r_phase <= ~r_phase;
      if (!r_phase) begin
        r_ir    <= rom_data;
        r_valid <= 1'b1;
      end else
        r_pc <= load_pc ? load_addr : r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  assign pc_addr  = r_pc;
  assign instr    = r_ir[7:4];
  assign oprnd    = r_ir[3:0];
  assign phase    = r_phase;
  assign ir_valid = r_valid;
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: ADDR_W, 12, program-memory address width (4096 bytes).
REQ-002 Parameter: RESET_VECTOR, 12'h000, PC value after reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  fetch/execute advance; low = hold all state.
REQ-006 load_pc  input  1  jump request, sampled only in execute phase.
REQ-007 load_addr  input  ADDR_W  jump target.
REQ-008 rom_data  input  8  program byte from program ROM (combinational read of pc_addr).
REQ-009 pc_addr  output  ADDR_W  current PC, drives ROM address.
REQ-010 instr  output  4  instruction register bits [7:4].
REQ-011 oprnd  output  4  instruction register bits [3:0].
REQ-012 phase  output  1  0 = fetch, 1 = execute.
REQ-013 ir_valid  output  1  high while IR holds a byte fetched since reset.
REQ-014 halted  output  1  sticky wrap-halt flag (see Configuration).

Function
REQ-015 pc_addr SHALL equal the PC register directly, no combinational path from any input.
REQ-016 Two-state machine FETCH(phase=0) -> EXECUTE(phase=1) -> FETCH, advancing one state per rising edge with enable=1 and halted=0.
REQ-017 FETCH edge: IR <= rom_data; phase <= 1; ir_valid <= 1; PC unchanged.
REQ-018 EXECUTE edge: load_pc=1 -> PC <= load_addr; else PC <= PC+1 modulo 2^ADDR_W; phase <= 0; IR unchanged.
REQ-019 load_pc during FETCH SHALL be ignored and have no later effect.
REQ-020 enable=0: PC, IR, phase, ir_valid, halted all hold.
REQ-021 halted=1: PC, IR, phase hold regardless of enable/load_pc until reset.
REQ-022 instr/oprnd are pure slices of IR; each instruction takes exactly 2 enabled cycles; byte at address N appears on instr/oprnd after the FETCH edge with pc_addr=N.
REQ-023 load_pc with load_addr equal to current PC SHALL reload same address (self-loop), no increment.

Reset
REQ-024 reset asserted (asynchronous): PC=RESET_VECTOR, IR=8'h00, phase=0, ir_valid=0, halted=0, immediately, without clock.
REQ-025 reset mid-EXECUTE with load_pc=1 SHALL discard the jump; first post-reset edge is a FETCH at RESET_VECTOR.
REQ-026 Deassertion SHALL take effect on the next rising edge with no extra idle cycle.

Configuration
REQ-027 Macro FETCH_WRAP_HALT_EN.
REQ-028 Defined: EXECUTE increment from all-ones PC (no load_pc) SHALL set PC=0 and halted=1; halted then freezes per REQ-021.
REQ-029 Undefined: PC wraps all-ones -> 0 silently; halted tied to 0; load_pc behaviour identical in both builds.

Verification
REQ-030 Reset, ROM[0]=8'h3A, ROM[1]=8'h51, enable=1 -> edge1: instr=3 oprnd=A phase=1; edge2: pc_addr=1; edge3: instr=5 oprnd=1.
REQ-031 In EXECUTE, load_pc=1 load_addr=12'h7F0 -> next pc_addr=12'h7F0; same request during FETCH -> pc_addr unchanged, then increments normally.
REQ-032 enable=0 for 5 cycles mid-EXECUTE -> pc_addr, instr, oprnd, phase constant; resume completes same instruction.
REQ-033 PC=12'hFFF, no load, FETCH_WRAP_HALT_EN defined -> pc_addr=0, halted=1, further edges frozen; undefined -> pc_addr=0, halted=0, fetch continues at 0.
REQ-034 Assert reset asynchronously between edges during EXECUTE with load_pc=1 -> outputs reset before next edge; pc_addr=RESET_VECTOR, ir_valid=0.
